// File: rtl/iomem_timer.sv
// rtl/iomem_timer.sv - memory-mapped 32-bit timer/compare peripheral on the iomem bus
//
// Ports:
//   clk, resetn         system clock, synchronous active-low reset
//   iomem_valid         bus request valid
//   iomem_ready         one-cycle acknowledge (registered)
//   iomem_wstrb[3:0]    byte write strobes, 0 = read
//   iomem_addr[31:0]    byte address; [31:24] must equal ADDR_HI, [4:2] selects the register
//   iomem_wdata[31:0]   write data
//   iomem_rdata[31:0]   read data, valid while iomem_ready = 1 (pre-write value)
//   irq                 level interrupt, registered match & irq_en
//
// Register map (iomem_addr[4:2]):
//   0 CTRL {irq_en, autoreload, en}   1 PRESCALE[15:0]   2 COMPARE
//   3 COUNT                           4 STATUS {match}, write 1 to clear
//   5-7 read 0, writes ignored

module iomem_timer #(
    parameter logic [7:0] ADDR_HI = 8'h04
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_COUNT    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    logic        en;
    logic        autoreload;
    logic        irq_en;
    logic [15:0] prescale;
    logic [31:0] compare;
    logic [31:0] count;
    logic        match;
    logic [15:0] pre_cnt;

    logic        sel;
    logic        wr;
    logic [2:0]  reg_idx;
    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic        tick;
    logic        hit;

    logic        unused_addr;
    assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

    // !iomem_ready gates selection so a held request is acknowledged only once
    assign sel     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
    assign wr      = sel && (iomem_wstrb != 4'b0000);
    assign reg_idx = iomem_addr[4:2];

    assign tick = en && (pre_cnt == prescale);
    assign hit  = (count == compare);

    always_comb begin
        rd_val = 32'h0;
        case (reg_idx)
            REG_CTRL:     rd_val = {29'h0, irq_en, autoreload, en};
            REG_PRESCALE: rd_val = {16'h0, prescale};
            REG_COMPARE:  rd_val = compare;
            REG_COUNT:    rd_val = count;
            REG_STATUS:   rd_val = {31'h0, match};
            default:      rd_val = 32'h0;
        endcase
    end

    // Byte-merged write value: unstrobed bytes keep the current register contents
    always_comb begin
        wr_val = rd_val;
        for (int b = 0; b < 4; b++) begin
            if (iomem_wstrb[b]) begin
                wr_val[8*b +: 8] = iomem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en          <= 1'b0;
            autoreload  <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 16'h0;
            compare     <= 32'h0;
            count       <= 32'h0;
            match       <= 1'b0;
            pre_cnt     <= 16'h0;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0;
            irq         <= 1'b0;
        end else begin
            iomem_ready <= sel;
            if (sel) begin
                iomem_rdata <= rd_val;
            end

            irq <= match & irq_en;

            // Counting; bus writes below are later in the block and therefore win
            if (en) begin
                if (tick) begin
                    pre_cnt <= 16'h0;
                    if (hit) begin
                        match <= 1'b1;
                        if (autoreload) begin
                            count <= 32'h0;
                        end else begin
                            en <= 1'b0;
                        end
                    end else begin
                        count <= count + 32'd1;
                    end
                end else begin
                    // Free 16-bit wrap keeps counting sane if PRESCALE drops below pre_cnt
                    pre_cnt <= pre_cnt + 16'd1;
                end
            end else begin
                pre_cnt <= 16'h0;
            end

            if (wr) begin
                case (reg_idx)
                    REG_CTRL: begin
                        // Only byte 0 holds control bits; without it a pending one-shot disable stands
                        if (iomem_wstrb[0]) begin
                            en         <= iomem_wdata[0];
                            autoreload <= iomem_wdata[1];
                            irq_en     <= iomem_wdata[2];
                            if (!iomem_wdata[0]) begin
                                pre_cnt <= 16'h0;
                            end
                        end
                    end
                    REG_PRESCALE: prescale <= wr_val[15:0];
                    REG_COMPARE:  compare  <= wr_val;
                    REG_COUNT:    count    <= wr_val;
                    REG_STATUS: begin
                        // A match set on this same edge takes priority over the clear
                        if (iomem_wstrb[0] && iomem_wdata[0] && !(tick && hit)) begin
                            match <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iomem_timer.sv
// tb/tb_iomem_timer.sv - directed self-checking bench for iomem_timer

module tb_iomem_timer;

    logic        clk;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    int vectors;
    int miscompares;

    localparam logic [31:0] BASE   = 32'h0400_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_CMP  = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    iomem_timer #(.ADDR_HI(8'h04)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; select edge is the first posedge, two cycles total
    task automatic xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input logic ack_exp, output logic [31:0] rd);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wd;
        @(posedge clk);
        #1;
        check("ack", {31'h0, iomem_ready}, {31'h0, ack_exp});
        rd = iomem_rdata;
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        check("ack_drop", {31'h0, iomem_ready}, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
        logic [31:0] dummy;
        xfer(addr, strb, wd, 1'b1, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        xfer(addr, 4'h0, 32'h0, 1'b1, d);
        check(tag, d, exp);
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        vectors     = 0;
        miscompares = 0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;

        // Reset state and all eight offsets read zero
        do_reset();
        check("rst_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd_chk("rst_reg", BASE + 32'(i * 4), 32'h0);
        end

        // Autoreload, PRESCALE=0, COMPARE=3; CTRL written at edge N
        do_reset();
        wr(A_PRE, 4'hF, 32'h0);
        wr(A_CMP, 4'hF, 32'h3);
        wr(A_CTRL, 4'hF, 32'h7);
        rd_chk("ar_cnt_n2", A_CNT, 32'h1);
        rd_chk("ar_cnt_n4", A_CNT, 32'h3);
        check("ar_irq_set", {31'h0, irq}, 32'h1);
        rd_chk("ar_status", A_STAT, 32'h1);
        rd_chk("ar_cnt_n8", A_CNT, 32'h3);
        check("ar_irq_hold", {31'h0, irq}, 32'h1);
        wr(A_STAT, 4'h1, 32'h1);
        check("ar_irq_clr", {31'h0, irq}, 32'h0);

        // One-shot, PRESCALE=4, COMPARE=2
        do_reset();
        wr(A_PRE, 4'hF, 32'h4);
        wr(A_CMP, 4'hF, 32'h2);
        wr(A_CTRL, 4'hF, 32'h1);
        rd_chk("os_cnt_n2", A_CNT, 32'h0);
        rd_chk("os_cnt_n4", A_CNT, 32'h0);
        rd_chk("os_cnt_n6", A_CNT, 32'h1);
        idle(10);
        rd_chk("os_cnt_end", A_CNT, 32'h2);
        rd_chk("os_ctrl", A_CTRL, 32'h0);
        rd_chk("os_status", A_STAT, 32'h1);
        check("os_irq", {31'h0, irq}, 32'h0);
        rd_chk("os_cnt_hold", A_CNT, 32'h2);

        // Byte strobes, masked register widths, out-of-window access
        do_reset();
        wr(A_CMP, 4'b0101, 32'hAABB_CCDD);
        rd_chk("strb_cmp", A_CMP, 32'h00BB_00DD);
        xfer(32'h0500_0008, 4'hF, 32'hFFFF_FFFF, 1'b0, d);
        check("oow_rdata_hold", iomem_rdata, 32'h00BB_00DD);
        rd_chk("oow_cmp", A_CMP, 32'h00BB_00DD);
        wr(A_PRE, 4'hF, 32'hFFFF_FFFF);
        rd_chk("pre_mask", A_PRE, 32'h0000_FFFF);
        wr(A_CTRL, 4'hF, 32'hFFFF_FFF8);
        rd_chk("ctrl_mask", A_CTRL, 32'h0);
        wr(BASE + 32'h14, 4'hF, 32'h1234_5678);
        rd_chk("reg5_zero", BASE + 32'h14, 32'h0);

        // Collisions: PRESCALE=3 gives ticks at N+4, N+8, N+12
        do_reset();
        wr(A_PRE, 4'hF, 32'h3);
        wr(A_CMP, 4'hF, 32'h101);
        wr(A_CTRL, 4'hF, 32'h1);
        idle(2);
        wr(A_CNT, 4'hF, 32'h100);
        rd_chk("col_cnt", A_CNT, 32'h100);
        idle(4);
        wr(A_STAT, 4'h1, 32'h1);
        rd_chk("col_match", A_STAT, 32'h1);
        rd_chk("col_ctrl", A_CTRL, 32'h0);

        // Wrap through 0xFFFFFFFF without a flag, match at COMPARE=5
        do_reset();
        wr(A_CNT, 4'hF, 32'hFFFF_FFFE);
        wr(A_CMP, 4'hF, 32'h5);
        wr(A_PRE, 4'hF, 32'h0);
        wr(A_CTRL, 4'hF, 32'h1);
        rd_chk("wrap_n2", A_CNT, 32'hFFFF_FFFF);
        rd_chk("wrap_n4", A_CNT, 32'h1);
        rd_chk("wrap_nomatch", A_STAT, 32'h0);
        rd_chk("wrap_n8", A_CNT, 32'h5);
        rd_chk("wrap_match", A_STAT, 32'h1);
        rd_chk("wrap_hold", A_CNT, 32'h5);

        // Reset arriving together with a read request drops the acknowledge
        iomem_valid = 1'b1;
        iomem_addr  = A_CNT;
        iomem_wstrb = 4'h0;
        resetn      = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ready", {31'h0, iomem_ready}, 32'h0);
        check("rst_mid_rdata", iomem_rdata, 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        resetn      = 1'b1;
        @(negedge clk);
        rd_chk("rst_mid_cnt", A_CNT, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped 32-bit timer/compare peripheral on the PicoSoC `iomem` bus, alongside the GPIO register in the top-level demo. It decodes its own address window and answers with the single-cycle `iomem_ready` handshake. It drives a level interrupt into one of the SoC's spare IRQ inputs (`irq_5`).

## Interface
Parameters:
- ADDR_HI, 8'h04, value `iomem_addr[31:24]` must match for the block to respond.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, synchronous, active-low
- iomem_valid  input  1  bus request valid
- iomem_ready  output  1  one-cycle acknowledge
- iomem_wstrb  input  4  byte write strobes; 0 = read
- iomem_addr  input  32  byte address
- iomem_wdata  input  32  write data
- iomem_rdata  output  32  read data, valid while `iomem_ready` = 1
- irq  output  1  level interrupt, `status.match & ctrl.irq_en`

## Operation
Registers are selected by `iomem_addr[4:2]`. All writes honour `wstrb` per byte.
- 0 CTRL: bit0 `en`, bit1 `autoreload`, bit2 `irq_en`; other bits read 0.
- 1 PRESCALE: bits [15:0]; upper bits read 0.
- 2 COMPARE: 32-bit.
- 3 COUNT: 32-bit, read/write.
- 4 STATUS: bit0 `match`. Writing 1 to bit0 (with `wstrb[0]`) clears it; writing 0 has no effect.
- 5–7: read 0, writes ignored, still acknowledged.

Bus handshake:
- Select = `iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_HI`.
- On select, the next edge sets `iomem_ready`=1 and loads `iomem_rdata` with the pre-write register value. The selected write is performed on the same edge.
- `iomem_ready` is 1 for exactly one cycle, then returns to 0.
- Transfers outside the window: no ack, no state change, `iomem_rdata` holds its value.

Counting (only while `en`=1):
- `pre_cnt` (16-bit) counts 0..PRESCALE. When `pre_cnt`==PRESCALE it returns to 0 and a `tick` occurs.
- On `tick` with COUNT==COMPARE:
  - `match` is set.
  - If `autoreload`=1, COUNT is set to 0.
  - If `autoreload`=0, COUNT holds and `en` is cleared (one-shot).
- On `tick` with COUNT!=COMPARE: COUNT increments by 1, wrapping 32'hFFFFFFFF -> 0 with no flag.
- While `en`=0: `pre_cnt` is held at 0 and COUNT is frozen.
- A write that clears `en` also zeroes `pre_cnt` on the same edge.

Simultaneous events:
- Bus write to COUNT in the same cycle as `tick`: the bus value wins and the tick increment is lost.
- W1C of `match` in the same cycle as a match: set wins and `match` stays 1.
- CTRL write in the same cycle as a one-shot auto-disable: the bus value of `en` wins.
- PRESCALE written below the current `pre_cnt`: `pre_cnt` continues counting, wraps at 16'hFFFF to 0, then matches normally. No lockup.

Reset:
- Synchronous, active-low.
- All registers, `pre_cnt`, `iomem_ready`, `iomem_rdata` and `irq` go to 0.
- Reset mid-transfer drops the acknowledge: `iomem_ready` = 0 on the next edge.

## Timing
- Select at edge N → `iomem_ready`=1 and `iomem_rdata` valid in cycle N+1. Write effects are visible from N+1.
- Back-to-back transfers: at most one ack every 2 cycles, because `!iomem_ready` gates selection.
- With PRESCALE=P, COUNT advances once every P+1 enabled cycles. P=0 means every cycle.
- First tick after enable occurs P+1 cycles after the `en` write edge.
- `match` rises on the tick edge where COUNT==COMPARE. `irq` is a registered AND and follows one cycle later.
- `irq` falls one cycle after either `match` or `irq_en` clears.

## Test plan
- Reset with `resetn`=0 for 2 cycles → all outputs 0; read each of offsets 0x00–0x1C at ADDR_HI → rdata 0, one-cycle ready per access.
- PRESCALE=0, COMPARE=3, CTRL=0x7 (autoreload) → COUNT sequence 0,1,2,3,0,1…; `match` set on the 3→0 edge; `irq`=1 one cycle later; W1C STATUS=1 → `irq` drops next cycle.
- PRESCALE=4, COMPARE=2, CTRL=0x1 (one-shot) → COUNT increments every 5 cycles; after the match tick COUNT stays 2, CTRL reads 0x0, `irq` stays 0 (`irq_en`=0), STATUS reads 1.
- Byte strobes: write COMPARE=0xAABBCCDD with wstrb=4'b0101 → reads 0x00BB00DD; write to address 0x05000000 → no ready, no change.
- Collision: COUNT write of 0x100 coinciding with a tick → COUNT reads 0x100. W1C coinciding with a match tick → `match` remains 1.
- Wrap: COUNT=0xFFFFFFFE, COMPARE=5, PRESCALE=0, en → COUNT goes 0xFFFFFFFF, 0, 1…; no `match` until COUNT=5. Assert `resetn` during an active read → ready 0 next cycle, COUNT 0.
